// File: rtl/walk_pkg.sv
// Shared types and helpers for the walk request bank: arbiter state encoding and clog2.
package walk_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/walk_channel.sv
// One request channel: edge register, pending flag, wait-age counter and expiry pulse.
module walk_channel
  import walk_pkg::*;
#(
  parameter int TIMEOUT = 200,
  parameter int AGE_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_clr,
  input  logic req,
  input  logic clear,
  input  logic granted,
  output logic pend,
  output logic expired
);

  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  logic             req_q;
  logic [AGE_W-1:0] age;
  logic             rise;
  logic             counting;
  logic             expire;

  assign rise     = req & ~req_q;
  assign counting = pend & ~granted;
  // A fresh rise keeps the request alive, so it also suppresses expiry in that cycle.
  assign expire   = (TIMEOUT > 0) && counting && (age == AGE_LAST) && !rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      pend    <= 1'b0;
      age     <= '0;
      expired <= 1'b0;
    end else if (sync_clr) begin
      req_q   <= req;
      pend    <= 1'b0;
      age     <= '0;
      expired <= 1'b0;
    end else begin
      req_q   <= req;
      expired <= expire;
      if (rise) begin
        pend <= 1'b1;
        age  <= '0;
      end else if (clear || expire) begin
        pend <= 1'b0;
        age  <= '0;
      end else if (!counting) begin
        age <= '0;
      end else if (age != AGE_MAX) begin
        age <= age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/walk_request_bank.sv
// Request bank top: N_CH walk channels plus a round-robin IDLE/GRANT arbiter.
// Handshake: grant_valid/grant_idx stay stable until a 1-cycle srv_ack; ack while idle is ignored.
module walk_request_bank
  import walk_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int TIMEOUT = 200,
  parameter int AGE_W   = 8
) (
  input  logic                     clk,
  input  logic                     Reset_n,
  input  logic                     Reset_sincronico,
  input  logic [N_CH-1:0]          req_in,
  input  logic                     srv_ack,
  output logic [N_CH-1:0]          pend,
  output logic                     grant_valid,
  output logic [clog2(N_CH)-1:0]   grant_idx,
  output logic [N_CH-1:0]          expired
);

  localparam int IDX_W = clog2(N_CH);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand_idx;
  logic [IDX_W-1:0] next_ptr;
  logic             found;
  logic             any_pend;
  int               cand;
  logic [N_CH-1:0]  granted;
  logic [N_CH-1:0]  clear;

  assign any_pend = |pend;
  assign next_ptr = (grant_idx == IDX_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;

  // First pending channel at or above ptr, wrapping modulo N_CH.
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_CH) cand = cand - N_CH;
      cand_idx = IDX_W'(cand);
      if (!found && pend[cand_idx]) begin
        pick  = cand_idx;
        found = 1'b1;
      end
    end
  end

  // A channel being granted this cycle counts as granted, so the grant beats expiry.
  always_comb begin
    granted = '0;
    clear   = '0;
    for (int i = 0; i < N_CH; i++) begin
      granted[i] = ((state == GRANT) && (grant_idx == IDX_W'(i))) ||
                   ((state == IDLE) && any_pend && (pick == IDX_W'(i)));
      clear[i]   = (state == GRANT) && srv_ack && (grant_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      ptr         <= '0;
    end else if (Reset_sincronico) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      ptr         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_pend) begin
            state       <= GRANT;
            grant_valid <= 1'b1;
            grant_idx   <= pick;
          end
        end
        GRANT: begin
          if (srv_ack) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            ptr         <= next_ptr;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    walk_channel #(
      .TIMEOUT (TIMEOUT),
      .AGE_W   (AGE_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (Reset_n),
      .sync_clr (Reset_sincronico),
      .req      (req_in[i]),
      .clear    (clear[i]),
      .granted  (granted[i]),
      .pend     (pend[i]),
      .expired  (expired[i])
    );
  end

endmodule

// File: tb/tb_walk_request_bank.sv
// Bench for walk_request_bank: vector table, directed corner sequences, random run vs reference model.
module tb_walk_request_bank;

  localparam int N  = 4;
  localparam int T  = 8;
  localparam int AW = 8;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Reset_sincronico = 1'b0;
  logic [3:0] req_in = '0;
  logic       srv_ack = 1'b0;
  logic [3:0] pend;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [3:0] expired;

  int checks = 0;
  int errors = 0;

  walk_request_bank #(.N_CH(N), .TIMEOUT(T), .AGE_W(AW)) dut (
    .clk              (clk),
    .Reset_n          (Reset_n),
    .Reset_sincronico (Reset_sincronico),
    .req_in           (req_in),
    .srv_ack          (srv_ack),
    .pend             (pend),
    .grant_valid      (grant_valid),
    .grant_idx        (grant_idx),
    .expired          (expired)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // reference model: cycles each pending request has waited, current grant, rotating start
  bit [3:0] m_pend;
  bit [3:0] m_exp;
  bit [3:0] m_req_q;
  int       m_wait[N];
  bit       m_gv;
  int       m_gi;
  int       m_ptr;

  function automatic void model_reset();
    m_pend  = '0;
    m_exp   = '0;
    m_req_q = '0;
    m_gv    = 1'b0;
    m_gi    = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endfunction

  function automatic void model_step(input logic [3:0] req, input bit ack, input bit sync);
    int pick;
    int served;
    int holder;
    bit [3:0] n_pend;
    bit [3:0] n_exp;
    if (sync) begin
      model_reset();
      m_req_q = req;
      return;
    end
    pick = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (pick < 0 && m_pend[c]) pick = c;
    end
    served = (m_gv && ack) ? m_gi : -1;
    holder = m_gv ? m_gi : pick;
    for (int i = 0; i < N; i++) begin
      bit rise;
      bit waiting;
      rise     = req[i] && !m_req_q[i];
      waiting  = m_pend[i] && (i != holder);
      n_exp[i] = 1'b0;
      if (rise) begin
        n_pend[i] = 1'b1;
        m_wait[i] = 0;
      end else if (i == served) begin
        n_pend[i] = 1'b0;
        m_wait[i] = 0;
      end else if (waiting && T > 0 && m_wait[i] == T - 1) begin
        n_pend[i] = 1'b0;
        n_exp[i]  = 1'b1;
        m_wait[i] = 0;
      end else begin
        n_pend[i] = m_pend[i];
        m_wait[i] = waiting ? ((m_wait[i] < (1 << AW) - 1) ? m_wait[i] + 1 : m_wait[i]) : 0;
      end
    end
    if (m_gv) begin
      if (ack) begin
        m_gv  = 1'b0;
        m_ptr = (m_gi + 1) % N;
      end
    end else if (pick >= 0) begin
      m_gv = 1'b1;
      m_gi = pick;
    end
    m_pend  = n_pend;
    m_exp   = n_exp;
    m_req_q = req;
  endfunction

  // scoreboard
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model_pend", int'(pend), int'(m_pend));
    check("model_grant_valid", int'(grant_valid), int'(m_gv));
    if (m_gv) check("model_grant_idx", int'(grant_idx), m_gi);
    check("model_expired", int'(expired), int'(m_exp));
  endtask

  // driver: apply inputs, clock once, sample 1 ns after the edge
  task automatic step(input logic [3:0] req, input bit ack, input bit sync);
    req_in           = req;
    srv_ack          = ack;
    Reset_sincronico = sync;
    @(posedge clk);
    model_step(req, ack, sync);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic [3:0] req;
    bit         ack;
    logic [3:0] e_pend;
    bit         e_gv;
    int         e_gi;
    logic [3:0] e_exp;
  } vec_t;

  vec_t tbl[10];
  int   rr_order[5];

  initial begin
    logic [3:0] cur;
    int n;

    tbl[0] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 0, 4'b0000};
    tbl[1] = '{4'b0100, 1'b0, 4'b0100, 1'b0, 0, 4'b0000};
    tbl[2] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2, 4'b0000};
    tbl[3] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2, 4'b0000};
    tbl[4] = '{4'b0000, 1'b0, 4'b0100, 1'b1, 2, 4'b0000};
    tbl[5] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0, 4'b0000};
    tbl[6] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0, 4'b0000};
    tbl[7] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 0, 4'b0000};
    tbl[8] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1, 4'b0000};
    tbl[9] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 0, 4'b0000};
    rr_order = '{0, 1, 2, 3, 0};

    // reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pend", int'(pend), 0);
    check("reset_grant_valid", int'(grant_valid), 0);
    check("reset_grant_idx", int'(grant_idx), 0);
    check("reset_expired", int'(expired), 0);
    #2 Reset_n = 1'b1;

    // single request vectors
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].req, tbl[i].ack, 1'b0);
      check($sformatf("tbl%0d_pend", i), int'(pend), int'(tbl[i].e_pend));
      check($sformatf("tbl%0d_gv", i), int'(grant_valid), int'(tbl[i].e_gv));
      if (tbl[i].e_gv) check($sformatf("tbl%0d_gi", i), int'(grant_idx), tbl[i].e_gi);
      check($sformatf("tbl%0d_exp", i), int'(expired), int'(tbl[i].e_exp));
    end

    // round robin, one idle cycle between grants, re-raise ch0/ch3 after ch1 served
    step(4'b0000, 1'b0, 1'b1);
    cur = 4'b1111;
    step(cur, 1'b0, 1'b0);
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (!grant_valid && n < 10) begin
        step(cur, 1'b0, 1'b0);
        n++;
      end
      check($sformatf("rr_gap%0d", g), n, 1);
      check($sformatf("rr_order%0d", g), int'(grant_idx), rr_order[g]);
      if (g == 0) cur = 4'b0000;
      step(cur, 1'b1, 1'b0);
      if (g == 1) cur = 4'b1001;
    end

    // expiry of a waiting channel while another is held granted
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(4'b0011, 1'b0, 1'b0);
      check($sformatf("exp_pulse_k%0d", k), int'(expired[1]), (k == 8) ? 1 : 0);
      check($sformatf("exp_ch0_k%0d", k), int'(expired[0]), 0);
      if (k == 8) check("exp_pend1_cleared", int'(pend[1]), 0);
    end
    step(4'b0011, 1'b1, 1'b0);

    // ack and new rise on the same channel in the same cycle
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0011, 1'b1, 1'b0);
    check("ackrise_pend", int'(pend), 3);
    check("ackrise_gv", int'(grant_valid), 0);
    for (int k = 1; k <= 8; k++) begin
      step(4'b0011, 1'b0, 1'b0);
      if (k == 1) check("ackrise_next_grant", int'(grant_idx), 0);
      check($sformatf("ackrise_exp_k%0d", k), int'(expired[1]), (k == 8) ? 1 : 0);
    end
    step(4'b0011, 1'b1, 1'b0);
    step(4'b0011, 1'b1, 1'b0);
    check("idle_ack_gv", int'(grant_valid), 0);
    check("idle_ack_pend", int'(pend), 0);

    // synchronous clear with lines held high
    step(4'b0011, 1'b0, 1'b1);
    check("sync_clear_pend", int'(pend), 0);
    step(4'b0011, 1'b0, 1'b0);
    check("sync_hold_pend_a", int'(pend), 0);
    step(4'b0011, 1'b0, 1'b0);
    check("sync_hold_pend_b", int'(pend), 0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    check("sync_new_edge_pend", int'(pend), 3);

    // asynchronous reset mid-grant
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    #2;
    Reset_n = 1'b0;
    req_in  = 4'b0000;
    #1;
    model_reset();
    check("async_pend", int'(pend), 0);
    check("async_grant_valid", int'(grant_valid), 0);
    check("async_grant_idx", int'(grant_idx), 0);
    check("async_expired", int'(expired), 0);
    @(posedge clk);
    #1 Reset_n = 1'b1;
    for (int k = 0; k < 3; k++) step(4'b0000, 1'b0, 1'b0);

    // randomized traffic
    cur = 4'b0000;
    for (int it = 0; it < 3000; it++) begin
      bit ack;
      bit sync;
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
      ack  = grant_valid ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      sync = ($urandom_range(0, 299) == 0);
      step(cur, ack, sync);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
